// File: rtl/nic8_pkg.sv
// Shared types and constants for the nic8 output display: conversion FSM states
// and the seven-segment glyph table.
package nic8_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    localparam int          DATA_W    = 8;
    localparam int          BCD_W     = 12;
    localparam int          SHIFT_W   = BCD_W + DATA_W;
    localparam logic [6:0]  SEG_BLANK = 7'b0000000;
    localparam logic [6:0]  SEG_ZERO  = 7'b0111111;

    // Segment order {g,f,e,d,c,b,a}, active-high; codes 10..15 are dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] i_digit);
        logic [6:0] r_pat;
        case (i_digit)
            4'd0:    r_pat = 7'b0111111;
            4'd1:    r_pat = 7'b0000110;
            4'd2:    r_pat = 7'b1011011;
            4'd3:    r_pat = 7'b1001111;
            4'd4:    r_pat = 7'b1100110;
            4'd5:    r_pat = 7'b1101101;
            4'd6:    r_pat = 7'b1111101;
            4'd7:    r_pat = 7'b0000111;
            4'd8:    r_pat = 7'b1111111;
            4'd9:    r_pat = 7'b1101111;
            default: r_pat = SEG_BLANK;
        endcase
        return r_pat;
    endfunction

endpackage

// File: rtl/out_bcd_conv.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with a
// single-entry pending slot so that writes arriving mid-conversion are not lost.
module out_bcd_conv
    import nic8_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              out_strobe,
    input  logic [DATA_W-1:0] out_data,
    output logic [BCD_W-1:0]  bcd,
    output logic              busy
);

    conv_state_t        r_state;
    conv_state_t        w_state_nxt;
    logic [SHIFT_W-1:0] r_shift;
    logic [SHIFT_W-1:0] w_adj;
    logic [2:0]         r_cnt;
    logic [DATA_W-1:0]  r_pend;
    logic               r_pend_v;
    logic [BCD_W-1:0]   r_bcd;
    logic               w_load_new;
    logic               w_load_pend;
    logic               w_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (out_strobe) w_state_nxt = CONV;
            CONV:    if (r_cnt == 3'd7) w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = (out_strobe || r_pend_v) ? CONV : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != IDLE) || r_pend_v;
    end

    assign busy = w_busy;
    assign bcd  = r_bcd;

    // A fresh strobe in COMMIT outranks the pending value, which then waits one more round.
    assign w_load_new  = out_strobe && ((r_state == IDLE) || (r_state == COMMIT));
    assign w_load_pend = (r_state == COMMIT) && !out_strobe && r_pend_v;

    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < 3; i++) begin
            if (r_shift[DATA_W + 4*i +: 4] >= 4'd5) begin
                w_adj[DATA_W + 4*i +: 4] = r_shift[DATA_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_bcd    <= '0;
        end else begin
            if (w_load_new) begin
                r_shift <= {{BCD_W{1'b0}}, out_data};
                r_cnt   <= '0;
            end else if (w_load_pend) begin
                r_shift <= {{BCD_W{1'b0}}, r_pend};
                r_cnt   <= '0;
            end else if (r_state == CONV) begin
                r_shift <= {w_adj[SHIFT_W-2:0], 1'b0};
                r_cnt   <= r_cnt + 3'd1;
            end

            if (r_state == COMMIT) begin
                r_bcd <= r_shift[SHIFT_W-1:DATA_W];
            end

            if ((r_state == CONV) && out_strobe) begin
                r_pend   <= out_data;
                r_pend_v <= 1'b1;
            end else if (w_load_pend) begin
                r_pend_v <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/out_display.sv
// Three-digit multiplexed seven-segment driver for the nic8 output port:
// converts each written byte to BCD and scans it out with optional zero blanking.
module out_display
    import nic8_pkg::*;
#(
    parameter int SCAN_DIV       = 1024,
    parameter bit BLANK_LEADING  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              out_strobe,
    input  logic [DATA_W-1:0] out_data,
    output logic [6:0]        seg,
    output logic [2:0]        dig_en,
    output logic [BCD_W-1:0]  bcd,
    output logic              busy
);

    localparam int               PRE_W   = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);
    localparam logic [6:0]       SEG_RST = SEG_ACTIVE_LOW ? ~SEG_ZERO : SEG_ZERO;
    localparam logic [2:0]       DIG_RST = SEG_ACTIVE_LOW ? 3'b110 : 3'b001;

    logic [BCD_W-1:0] w_bcd;
    logic             w_busy;
    logic [PRE_W-1:0] r_presc;
    logic [1:0]       r_dig_idx;
    logic [3:0]       w_hund;
    logic [3:0]       w_tens;
    logic [3:0]       w_ones;
    logic [3:0]       w_nib;
    logic             w_blank;
    logic [6:0]       w_seg_ah;
    logic [2:0]       w_dig_ah;
    logic [6:0]       r_seg;
    logic [2:0]       r_dig_en;

    out_bcd_conv u_conv (
        .clk        (clk),
        .reset_n    (reset_n),
        .out_strobe (out_strobe),
        .out_data   (out_data),
        .bcd        (w_bcd),
        .busy       (w_busy)
    );

    // Free-running scanner, deliberately unaware of conversion activity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc   <= '0;
            r_dig_idx <= 2'd0;
        end else if (r_presc == PRE_MAX) begin
            r_presc   <= '0;
            r_dig_idx <= (r_dig_idx == 2'd2) ? 2'd0 : r_dig_idx + 2'd1;
        end else begin
            r_presc   <= r_presc + 1'b1;
        end
    end

    always_comb begin
        w_hund   = w_bcd[11:8];
        w_tens   = w_bcd[7:4];
        w_ones   = w_bcd[3:0];
        w_nib    = w_ones;
        w_blank  = 1'b0;
        w_dig_ah = 3'b001;
        case (r_dig_idx)
            2'd1: begin
                w_nib    = w_tens;
                w_blank  = BLANK_LEADING && (w_hund == 4'd0) && (w_tens == 4'd0);
                w_dig_ah = 3'b010;
            end
            2'd2: begin
                w_nib    = w_hund;
                w_blank  = BLANK_LEADING && (w_hund == 4'd0);
                w_dig_ah = 3'b100;
            end
            default: ;
        endcase
        w_seg_ah = w_blank ? SEG_BLANK : seg_decode(w_nib);
    end

    // Pin registers hold the final polarity so the outputs never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_seg    <= SEG_RST;
            r_dig_en <= DIG_RST;
        end else begin
            r_seg    <= SEG_ACTIVE_LOW ? ~w_seg_ah : w_seg_ah;
            r_dig_en <= SEG_ACTIVE_LOW ? ~w_dig_ah : w_dig_ah;
        end
    end

    assign seg    = r_seg;
    assign dig_en = r_dig_en;
    assign bcd    = w_bcd;
    assign busy   = w_busy;

endmodule

// File: tb/tb_out_display.sv
// Testbench for out_display: directed scenarios plus a randomized run against a
// timing-level behavioural model of the write/convert/commit behaviour.
module tb_out_display;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       out_strobe = 1'b0;
    logic [7:0] out_data = 8'd0;

    logic [6:0]  seg_a, seg_b, seg_c;
    logic [2:0]  dig_a, dig_b, dig_c;
    logic [11:0] bcd_a, bcd_b, bcd_c;
    logic        busy_a, busy_b, busy_c;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: pending/active bookkeeping in cycles-to-commit.
    bit          m_active = 1'b0;
    int          m_remain = 0;
    int          m_val = 0;
    bit          m_pend_v = 1'b0;
    int          m_pend = 0;
    logic [11:0] m_bcd = 12'h000;
    logic [11:0] m_bcd_prev = 12'h000;

    always #5 clk = ~clk;

    out_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .out_strobe(out_strobe), .out_data(out_data),
        .seg(seg_a), .dig_en(dig_a), .bcd(bcd_a), .busy(busy_a));

    out_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .out_strobe(out_strobe), .out_data(out_data),
        .seg(seg_b), .dig_en(dig_b), .bcd(bcd_b), .busy(busy_b));

    out_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_c (
        .clk(clk), .reset_n(reset_n), .out_strobe(out_strobe), .out_data(out_data),
        .seg(seg_c), .dig_en(dig_c), .bcd(bcd_c), .busy(busy_c));

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] digit_pat(input logic [3:0] d);
        logic [6:0] tab [0:9];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (d > 4'd9) return 7'h00;
        return tab[d];
    endfunction

    // Expected active-high segments for the digit selected by a one-hot enable.
    function automatic logic [6:0] exp_seg(input logic [2:0] en, input logic [11:0] b, input bit blank);
        logic [6:0] r;
        case (en)
            3'b001:  r = digit_pat(b[3:0]);
            3'b010:  r = (blank && b[11:8] == 4'd0 && b[7:4] == 4'd0) ? 7'h00 : digit_pat(b[7:4]);
            3'b100:  r = (blank && b[11:8] == 4'd0) ? 7'h00 : digit_pat(b[11:8]);
            default: r = 7'bxxxxxxx;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_active = 1'b0; m_remain = 0; m_pend_v = 1'b0;
        m_bcd = 12'h000; m_bcd_prev = 12'h000;
    endtask

    task automatic model_edge(input bit s, input int d);
        m_bcd_prev = m_bcd;
        if (!reset_n) begin
            model_reset();
        end else if (!m_active) begin
            if (s) begin m_active = 1'b1; m_remain = 9; m_val = d; end
        end else begin
            m_remain--;
            if (m_remain == 0) begin
                m_bcd = to_bcd(m_val);
                if (s) begin m_val = d; m_remain = 9; end
                else if (m_pend_v) begin m_val = m_pend; m_pend_v = 1'b0; m_remain = 9; end
                else m_active = 1'b0;
            end else if (s) begin
                m_pend = d; m_pend_v = 1'b1;
            end
        end
    endtask

    task automatic step(input bit s, input logic [7:0] d);
        out_strobe = s;
        out_data   = d;
        @(posedge clk);
        #1;
        model_edge(s, int'(d));
        out_strobe = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step(1'b0, 8'd0);
        vectors++; if (bcd_a !== 12'h000) begin miscompares++; $display("FAIL reset_bcd: got %h want 000", bcd_a); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        vectors++; if (dig_a !== 3'b001) begin miscompares++; $display("FAIL reset_dig: got %b want 001", dig_a); end
        vectors++; if (seg_a !== 7'b0111111) begin miscompares++; $display("FAIL reset_seg: got %b want 0111111", seg_a); end
        vectors++; if (seg_c !== 7'b1000000) begin miscompares++; $display("FAIL reset_seg_pins: got %b want 1000000", seg_c); end
        vectors++; if (dig_c !== 3'b110) begin miscompares++; $display("FAIL reset_dig_pins: got %b want 110", dig_c); end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        step(1'b1, 8'd173);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 8'd0);
            vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL single_busy E%0d: got %b want 1", k, busy_a); end
            vectors++; if (bcd_a !== 12'h000) begin miscompares++; $display("FAIL single_hold E%0d: got %h want 000", k, bcd_a); end
        end
        step(1'b0, 8'd0);
        vectors++; if (bcd_a !== 12'h173) begin miscompares++; $display("FAIL single_bcd: got %h want 173", bcd_a); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL single_done: got %b want 0", busy_a); end
    endtask

    task automatic test_boundaries();
        logic [7:0]  vals [4];
        logic [11:0] exps [4];
        vals = '{8'd0, 8'd255, 8'd9, 8'd10};
        exps = '{12'h000, 12'h255, 12'h009, 12'h010};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vals[i]);
            repeat (9) step(1'b0, 8'd0);
            vectors++; if (bcd_a !== exps[i]) begin miscompares++; $display("FAIL boundary_%0d: got %h want %h", vals[i], bcd_a, exps[i]); end
            vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL boundary_busy_%0d: got %b want 0", vals[i], busy_a); end
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 8'd5);
        repeat (2) step(1'b0, 8'd0);
        step(1'b1, 8'd250);
        step(1'b0, 8'd0);
        step(1'b1, 8'd99);
        repeat (3) step(1'b0, 8'd0);
        step(1'b0, 8'd0);
        vectors++; if (bcd_a !== 12'h005) begin miscompares++; $display("FAIL b2b_first: got %h want 005", bcd_a); end
        vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL b2b_busy: got %b want 1", busy_a); end
        for (int k = 10; k <= 17; k++) begin
            step(1'b0, 8'd0);
            vectors++; if (bcd_a !== 12'h005) begin miscompares++; $display("FAIL b2b_hold E%0d: got %h want 005", k, bcd_a); end
        end
        step(1'b0, 8'd0);
        vectors++; if (bcd_a !== 12'h099) begin miscompares++; $display("FAIL b2b_last: got %h want 099", bcd_a); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got %b want 0", busy_a); end
    endtask

    task automatic test_commit_strobe();
        step(1'b1, 8'd42);
        repeat (2) step(1'b0, 8'd0);
        step(1'b1, 8'd77);
        repeat (5) step(1'b0, 8'd0);
        step(1'b1, 8'd123);
        vectors++; if (bcd_a !== 12'h042) begin miscompares++; $display("FAIL commit_first: got %h want 042", bcd_a); end
        vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL commit_busy: got %b want 1", busy_a); end
        repeat (9) step(1'b0, 8'd0);
        vectors++; if (bcd_a !== 12'h123) begin miscompares++; $display("FAIL commit_strobe_val: got %h want 123", bcd_a); end
        repeat (9) step(1'b0, 8'd0);
        vectors++; if (bcd_a !== 12'h077) begin miscompares++; $display("FAIL commit_pend_val: got %h want 077", bcd_a); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL commit_idle: got %b want 0", busy_a); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 8'd200);
        repeat (3) step(1'b0, 8'd0);
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (bcd_a !== 12'h000) begin miscompares++; $display("FAIL midreset_bcd: got %h want 000", bcd_a); end
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", busy_a); end
        vectors++; if (dig_a !== 3'b001) begin miscompares++; $display("FAIL midreset_dig: got %b want 001", dig_a); end
        vectors++; if (seg_c !== 7'b1000000) begin miscompares++; $display("FAIL midreset_seg_pins: got %b want 1000000", seg_c); end
        model_reset();
        step(1'b0, 8'd0);
        reset_n = 1'b1;
        repeat (12) step(1'b0, 8'd0);
        vectors++; if (bcd_a !== 12'h000) begin miscompares++; $display("FAIL midreset_discard: got %h want 000", bcd_a); end
    endtask

    task automatic test_scan();
        logic [2:0] prev_en;
        int run;
        bit started;
        step(1'b1, 8'd7);
        repeat (12) step(1'b0, 8'd0);
        prev_en = dig_a; run = 0; started = 1'b0;
        for (int c = 0; c < 24; c++) begin
            step(1'b0, 8'd0);
            vectors++; if (seg_a !== ((dig_a == 3'b001) ? 7'h07 : 7'h00)) begin miscompares++; $display("FAIL scan_blank en=%b: got %b", dig_a, seg_a); end
            vectors++; if (seg_b !== ((dig_b == 3'b001) ? 7'h07 : 7'h3F)) begin miscompares++; $display("FAIL scan_noblank en=%b: got %b", dig_b, seg_b); end
            if (dig_a != prev_en) begin
                if (started) begin
                    vectors++; if (run != 4) begin miscompares++; $display("FAIL scan_dwell: got %0d want 4", run); end
                end
                vectors++; if (dig_a !== {prev_en[1:0], prev_en[2]}) begin miscompares++; $display("FAIL scan_order: got %b want %b", dig_a, {prev_en[1:0], prev_en[2]}); end
                started = 1'b1; run = 1; prev_en = dig_a;
            end else begin
                run++;
            end
        end
    endtask

    task automatic test_polarity();
        logic [6:0] want;
        step(1'b1, 8'd88);
        repeat (12) step(1'b0, 8'd0);
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 8'd0);
            want = (dig_c == 3'b011) ? 7'b1111111 : 7'b0000000;
            vectors++; if (seg_c !== want) begin miscompares++; $display("FAIL polarity_seg en=%b: got %b want %b", dig_c, seg_c, want); end
            vectors++; if ($countones(dig_c) != 2) begin miscompares++; $display("FAIL polarity_dig: got %b want one low bit", dig_c); end
        end
    endtask

    task automatic test_random();
        bit s;
        logic [7:0] d;
        for (int c = 0; c < 400; c++) begin
            s = ($urandom_range(0, 5) == 0);
            d = 8'($urandom_range(0, 255));
            step(s, d);
            vectors++; if (bcd_a !== m_bcd) begin miscompares++; $display("FAIL rand_bcd c%0d: got %h want %h", c, bcd_a, m_bcd); end
            vectors++; if (busy_a !== (m_active || m_pend_v)) begin miscompares++; $display("FAIL rand_busy c%0d: got %b want %b", c, busy_a, m_active || m_pend_v); end
            vectors++; if (seg_a !== exp_seg(dig_a, m_bcd_prev, 1'b1)) begin miscompares++; $display("FAIL rand_seg_a c%0d: got %b want %b", c, seg_a, exp_seg(dig_a, m_bcd_prev, 1'b1)); end
            vectors++; if (seg_b !== exp_seg(dig_b, m_bcd_prev, 1'b0)) begin miscompares++; $display("FAIL rand_seg_b c%0d: got %b want %b", c, seg_b, exp_seg(dig_b, m_bcd_prev, 1'b0)); end
            vectors++; if (seg_c !== ~exp_seg(~dig_c, m_bcd_prev, 1'b1)) begin miscompares++; $display("FAIL rand_seg_c c%0d: got %b want %b", c, seg_c, ~exp_seg(~dig_c, m_bcd_prev, 1'b1)); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundaries();
        test_back_to_back();
        test_commit_strobe();
        test_reset_mid();
        test_scan();
        test_polarity();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
